write_txn_controller: RTL and testbench
=======================================

WRITE_TXN_CONTROLLER -- requirements
Module: write_txn_controller

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, meaning the AW address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, meaning the W data width.
REQ-003 The block SHALL have ports as listed below, one per line as name, direction, width, meaning; packed per-master vectors put master 0 in the low slice.
- ACLK  in  1  clock; all state updates on its rising edge.
- ARESETN  in  1  reset; asynchronous, active-low.
- Channel_Request  in  1  arbiter request; a master is waiting.
- Selected_Slave  in  1  registered arbiter choice (0=M0, 1=M1).
- Channel_Granted  out  1  channel free; high only in IDLE.
- S_AXI_awaddr  in  2*ADDR_WIDTH  master AW addresses.
- S_AXI_awvalid  in  2  master AW valid.
- S_AXI_awready  out  2  master AW ready.
- S_AXI_wdata  in  2*DATA_WIDTH  master W data.
- S_AXI_wlast  in  2  master W last.
- S_AXI_wvalid  in  2  master W valid.
- S_AXI_wready  out  2  master W ready.
- S_AXI_bresp  out  4  master B response, 2 bits per master.
- S_AXI_bvalid  out  2  master B valid.
- S_AXI_bready  in  2  master B ready.
- M00_AXI_awaddr/awvalid  out  ADDR_WIDTH/1  slave AW address and valid.
- M00_AXI_awready  in  1  slave AW ready.
- M00_AXI_wdata/wlast/wvalid  out  DATA_WIDTH/1/1  slave W data, last and valid.
- M00_AXI_wready  in  1  slave W ready.
- M00_AXI_bresp/bvalid  in  2/1  slave B response and valid.
- M00_AXI_bready  out  1  slave B ready.
- Beat_Count  out  8  W beats accepted in the current transaction, saturating at 255.

Function
REQ-004 The FSM SHALL have states IDLE, CAPTURE, ADDR, DATA and RESP, with state held in a register.
REQ-005 Channel_Granted SHALL equal (state==IDLE), combinationally from the state register only.
REQ-006 In IDLE with Channel_Request=1 at a rising edge, the FSM SHALL go to CAPTURE; otherwise it SHALL stay in IDLE.
REQ-007 CAPTURE SHALL last exactly one cycle and latch Owner<=Selected_Slave, clear Beat_Count to 0, then go to ADDR.
REQ-008 In ADDR, M00_AXI_awvalid/awaddr SHALL equal S_AXI_awvalid/awaddr of Owner, and S_AXI_awready[Owner] SHALL equal M00_AXI_awready.
REQ-009 When M00_AXI_awvalid & M00_AXI_awready at an edge in ADDR, the FSM SHALL go to DATA.
REQ-010 In DATA, M00_AXI_wvalid/wdata/wlast SHALL follow the Owner slice, and S_AXI_wready[Owner] SHALL equal M00_AXI_wready.
REQ-011 In DATA, each edge with wvalid & wready SHALL increment Beat_Count, saturating at 255.
REQ-012 In DATA, a beat with wlast=1 SHALL move the FSM to RESP.
REQ-013 In RESP, S_AXI_bvalid[Owner] and S_AXI_bresp[Owner] SHALL follow M00_AXI_bvalid and M00_AXI_bresp.
REQ-014 In RESP, M00_AXI_bready SHALL equal S_AXI_bready[Owner], and a B handshake SHALL return the FSM to IDLE.
REQ-015 Every slave-bound valid and every master-bound ready or valid SHALL be 0 outside its active state.
REQ-016 Every signal on the non-Owner master SHALL be 0 at all times.
REQ-017 M00_AXI_bready SHALL be 0 outside RESP.
REQ-018 W beats offered before ADDR completes SHALL stall (wready=0); no W data SHALL pass before the AW handshake.
REQ-019 Beat_Count SHALL hold its value in IDLE, ADDR and RESP.
REQ-020 Every forwarding path SHALL be combinational with zero added latency; a handshake completes in the cycle both sides are high.
REQ-021 Minimum turnaround SHALL be 1 cycle in each of IDLE, CAPTURE, ADDR, DATA and RESP: a single-beat write with all readies high occupies 5 cycles.
REQ-022 Owner SHALL be stable from CAPTURE until the FSM returns to IDLE, regardless of changes on Selected_Slave.
REQ-023 Changes on Channel_Request outside IDLE SHALL have no effect.

Reset
REQ-024 With ARESETN=0, the block SHALL immediately and asynchronously set: state=IDLE, Owner=0, Beat_Count=0, Channel_Granted=1, all other outputs 0.
REQ-025 Reset asserted mid-transaction SHALL abort it with no further handshakes, and the block SHALL come out of reset in IDLE.

Verification
REQ-026 Single beat, M0: Request at T0, Selected_Slave=0, readies high, wlast=1 -> AW fire T2, W fire T3, B fire T4; Channel_Granted high again T5; Beat_Count=1.
REQ-027 Burst, M1: 4 beats with M00_AXI_wready toggled 1,0,1,... -> exactly 4 beats forwarded in order; Beat_Count=4; S_AXI_wready[0]=0 throughout.
REQ-028 Early W: M0 drives wvalid before awvalid -> S_AXI_wready[0]=0 until AW handshake; no wvalid on M00 before DATA.
REQ-029 Selected_Slave toggles 0->1 during DATA -> routing stays on M0 until B completes.
REQ-030 ARESETN pulse low during DATA -> all valids/readies 0 at once, Channel_Granted=1, Beat_Count=0; the next transaction completes normally.
REQ-031 B backpressure: bvalid high, S_AXI_bready[Owner]=0 for 3 cycles -> FSM stays in RESP and bvalid stays held; IDLE one cycle after bready=1.

Source files
------------

// File: rtl/write_txn_controller.sv
// Two-master to one-slave AXI write channel controller: arbitrated ownership,
// combinational forwarding of AW, W and B for the current owner, and a W beat counter.
module write_txn_controller #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic                    Channel_Request,
  input  logic                    Selected_Slave,
  output logic                    Channel_Granted,
  input  logic [2*ADDR_WIDTH-1:0] S_AXI_awaddr,
  input  logic [1:0]              S_AXI_awvalid,
  output logic [1:0]              S_AXI_awready,
  input  logic [2*DATA_WIDTH-1:0] S_AXI_wdata,
  input  logic [1:0]              S_AXI_wlast,
  input  logic [1:0]              S_AXI_wvalid,
  output logic [1:0]              S_AXI_wready,
  output logic [3:0]              S_AXI_bresp,
  output logic [1:0]              S_AXI_bvalid,
  input  logic [1:0]              S_AXI_bready,
  output logic [ADDR_WIDTH-1:0]   M00_AXI_awaddr,
  output logic                    M00_AXI_awvalid,
  input  logic                    M00_AXI_awready,
  output logic [DATA_WIDTH-1:0]   M00_AXI_wdata,
  output logic                    M00_AXI_wlast,
  output logic                    M00_AXI_wvalid,
  input  logic                    M00_AXI_wready,
  input  logic [1:0]              M00_AXI_bresp,
  input  logic                    M00_AXI_bvalid,
  output logic                    M00_AXI_bready,
  output logic [7:0]              Beat_Count,
  output logic [2:0]              fsm_state
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_ADDR    = 3'd2,
    ST_DATA    = 3'd3,
    ST_RESP    = 3'd4
  } state_t;

  state_t state;
  logic   owner;

  logic                  own_awvalid;
  logic                  own_wvalid;
  logic                  own_wlast;
  logic                  own_bready;
  logic [ADDR_WIDTH-1:0] own_awaddr;
  logic [DATA_WIDTH-1:0] own_wdata;
  logic                  aw_fire;
  logic                  w_fire;
  logic                  b_fire;

  // Owner-slice selection of the master-side inputs.
  assign own_awvalid = S_AXI_awvalid[owner];
  assign own_wvalid  = S_AXI_wvalid[owner];
  assign own_wlast   = S_AXI_wlast[owner];
  assign own_bready  = S_AXI_bready[owner];
  assign own_awaddr  = owner ? S_AXI_awaddr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                             : S_AXI_awaddr[ADDR_WIDTH-1:0];
  assign own_wdata   = owner ? S_AXI_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                             : S_AXI_wdata[DATA_WIDTH-1:0];

  // Handshakes are valid/ready pairs: a transfer completes on the rising edge
  // where both are high; valid never waits on ready.
  assign aw_fire = (state == ST_ADDR) && own_awvalid && M00_AXI_awready;
  assign w_fire  = (state == ST_DATA) && own_wvalid  && M00_AXI_wready;
  assign b_fire  = (state == ST_RESP) && M00_AXI_bvalid && own_bready;

  assign Channel_Granted = (state == ST_IDLE);
  assign fsm_state       = state;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state      <= ST_IDLE;
      owner      <= 1'b0;
      Beat_Count <= 8'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (Channel_Request) state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          owner      <= Selected_Slave;
          Beat_Count <= 8'd0;
          state      <= ST_ADDR;
        end
        ST_ADDR: begin
          if (aw_fire) state <= ST_DATA;
        end
        ST_DATA: begin
          if (w_fire) begin
            if (Beat_Count != 8'hFF) Beat_Count <= Beat_Count + 8'd1;
            if (own_wlast) state <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (b_fire) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Forwarding paths: only the active phase and only the owner slice are live.
  always_comb begin
    S_AXI_awready   = 2'b00;
    S_AXI_wready    = 2'b00;
    S_AXI_bresp     = 4'b0000;
    S_AXI_bvalid    = 2'b00;
    M00_AXI_awaddr  = '0;
    M00_AXI_awvalid = 1'b0;
    M00_AXI_wdata   = '0;
    M00_AXI_wlast   = 1'b0;
    M00_AXI_wvalid  = 1'b0;
    M00_AXI_bready  = 1'b0;
    case (state)
      ST_ADDR: begin
        M00_AXI_awvalid      = own_awvalid;
        M00_AXI_awaddr       = own_awaddr;
        S_AXI_awready[owner] = M00_AXI_awready;
      end
      ST_DATA: begin
        M00_AXI_wvalid      = own_wvalid;
        M00_AXI_wdata       = own_wdata;
        M00_AXI_wlast       = own_wlast;
        S_AXI_wready[owner] = M00_AXI_wready;
      end
      ST_RESP: begin
        S_AXI_bvalid[owner] = M00_AXI_bvalid;
        if (owner) S_AXI_bresp[3:2] = M00_AXI_bresp;
        else       S_AXI_bresp[1:0] = M00_AXI_bresp;
        M00_AXI_bready = own_bready;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_write_txn_controller.sv
// Bench for write_txn_controller: hand-derived vector table, directed
// transactions and random traffic checked against a transaction-level model.
module tb_write_txn_controller;

  localparam int AW = 32;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic ACLK = 1'b0;
  logic ARESETN;
  always #5 ACLK = ~ACLK;

  logic            Channel_Request, Selected_Slave, Channel_Granted;
  logic [2*AW-1:0] S_AXI_awaddr;
  logic [1:0]      S_AXI_awvalid, S_AXI_awready;
  logic [2*DW-1:0] S_AXI_wdata;
  logic [1:0]      S_AXI_wlast, S_AXI_wvalid, S_AXI_wready;
  logic [3:0]      S_AXI_bresp;
  logic [1:0]      S_AXI_bvalid, S_AXI_bready;
  logic [AW-1:0]   M00_AXI_awaddr;
  logic            M00_AXI_awvalid, M00_AXI_awready;
  logic [DW-1:0]   M00_AXI_wdata;
  logic            M00_AXI_wlast, M00_AXI_wvalid, M00_AXI_wready;
  logic [1:0]      M00_AXI_bresp;
  logic            M00_AXI_bvalid, M00_AXI_bready;
  logic [7:0]      Beat_Count;
  logic [2:0]      dbg_state;

  write_txn_controller #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .Channel_Request(Channel_Request), .Selected_Slave(Selected_Slave),
    .Channel_Granted(Channel_Granted),
    .S_AXI_awaddr(S_AXI_awaddr), .S_AXI_awvalid(S_AXI_awvalid), .S_AXI_awready(S_AXI_awready),
    .S_AXI_wdata(S_AXI_wdata), .S_AXI_wlast(S_AXI_wlast), .S_AXI_wvalid(S_AXI_wvalid),
    .S_AXI_wready(S_AXI_wready),
    .S_AXI_bresp(S_AXI_bresp), .S_AXI_bvalid(S_AXI_bvalid), .S_AXI_bready(S_AXI_bready),
    .M00_AXI_awaddr(M00_AXI_awaddr), .M00_AXI_awvalid(M00_AXI_awvalid),
    .M00_AXI_awready(M00_AXI_awready),
    .M00_AXI_wdata(M00_AXI_wdata), .M00_AXI_wlast(M00_AXI_wlast), .M00_AXI_wvalid(M00_AXI_wvalid),
    .M00_AXI_wready(M00_AXI_wready),
    .M00_AXI_bresp(M00_AXI_bresp), .M00_AXI_bvalid(M00_AXI_bvalid), .M00_AXI_bready(M00_AXI_bready),
    .Beat_Count(Beat_Count), .fsm_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int    n_vec = 0;
  int    n_bad = 0;
  string cur_test = "reset";

  typedef struct packed {
    logic          granted;
    logic [1:0]    s_awready;
    logic [1:0]    s_wready;
    logic [3:0]    s_bresp;
    logic [1:0]    s_bvalid;
    logic [AW-1:0] m_awaddr;
    logic          m_awvalid;
    logic [DW-1:0] m_wdata;
    logic          m_wlast;
    logic          m_wvalid;
    logic          m_bready;
    logic [7:0]    beat;
  } out_t;

  typedef struct {
    logic       req, sel, awr;
    logic       gr, m_awv, m_wv, m_br;
    logic [1:0] s_awr, s_wr, s_bv;
    logic [7:0] beat;
  } vec_t;

  vec_t tbl[$];
  bit   tbl_on = 0;
  int   tbl_idx = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got_q[$];

  // Transaction-level reference: progress flags of the current write.
  bit m_busy, m_cap, m_aw, m_w, m_owner;
  int m_beats;

  bit            aw_hs, w_hs, b_hs;
  logic [DW-1:0] w_seen;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic out_t model_out();
    out_t e;
    int   o;
    e = '0;
    o = int'(m_owner);
    e.granted = !m_busy;
    e.beat    = m_beats[7:0];
    if (m_busy && m_cap && !m_aw) begin
      e.m_awvalid    = S_AXI_awvalid[o];
      e.m_awaddr     = S_AXI_awaddr[o*AW +: AW];
      e.s_awready[o] = M00_AXI_awready;
    end else if (m_aw && !m_w) begin
      e.m_wvalid    = S_AXI_wvalid[o];
      e.m_wdata     = S_AXI_wdata[o*DW +: DW];
      e.m_wlast     = S_AXI_wlast[o];
      e.s_wready[o] = M00_AXI_wready;
    end else if (m_w) begin
      e.s_bvalid[o]       = M00_AXI_bvalid;
      e.s_bresp[2*o +: 2] = M00_AXI_bresp;
      e.m_bready          = S_AXI_bready[o];
    end
    return e;
  endfunction

  task automatic model_step();
    int o;
    o = int'(m_owner);
    if (!m_busy) begin
      if (Channel_Request) m_busy = 1;
    end else if (!m_cap) begin
      m_owner = Selected_Slave;
      m_beats = 0;
      m_cap   = 1;
    end else if (!m_aw) begin
      if (S_AXI_awvalid[o] && M00_AXI_awready) m_aw = 1;
    end else if (!m_w) begin
      if (S_AXI_wvalid[o] && M00_AXI_wready) begin
        if (m_beats < 255) m_beats++;
        if (S_AXI_wlast[o]) m_w = 1;
      end
    end else if (M00_AXI_bvalid && S_AXI_bready[o]) begin
      m_busy = 0; m_cap = 0; m_aw = 0; m_w = 0;
    end
  endtask

  // One clock: entered at posedge+1 with inputs driven, checks mid-cycle,
  // advances the model with the inputs the DUT samples, returns at posedge+1.
  task automatic cycle();
    out_t e, a;
    vec_t r;
    #2;
    if (!ARESETN) begin
      m_busy = 0; m_cap = 0; m_aw = 0; m_w = 0; m_owner = 0; m_beats = 0;
    end
    e = model_out();
    a = {Channel_Granted, S_AXI_awready, S_AXI_wready, S_AXI_bresp, S_AXI_bvalid,
         M00_AXI_awaddr, M00_AXI_awvalid, M00_AXI_wdata, M00_AXI_wlast, M00_AXI_wvalid,
         M00_AXI_bready, Beat_Count};
    chk({cur_test, " outputs"}, a, e);
    if (tbl_on) begin
      r = tbl[tbl_idx];
      chk($sformatf("table row %0d", tbl_idx),
          {Channel_Granted, M00_AXI_awvalid, M00_AXI_wvalid, M00_AXI_bready,
           S_AXI_awready, S_AXI_wready, S_AXI_bvalid, Beat_Count},
          {r.gr, r.m_awv, r.m_wv, r.m_br, r.s_awr, r.s_wr, r.s_bv, r.beat});
    end
    aw_hs  = M00_AXI_awvalid && M00_AXI_awready;
    w_hs   = M00_AXI_wvalid && M00_AXI_wready;
    b_hs   = M00_AXI_bvalid && M00_AXI_bready;
    w_seen = M00_AXI_wdata;
    if (ARESETN) model_step();
    @(posedge ACLK);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    Channel_Request = 0; Selected_Slave = 0;
    S_AXI_awaddr = '0; S_AXI_awvalid = '0; S_AXI_wdata = '0; S_AXI_wlast = '0;
    S_AXI_wvalid = '0; S_AXI_bready = '0;
    M00_AXI_awready = 0; M00_AXI_wready = 0; M00_AXI_bresp = '0; M00_AXI_bvalid = 0;
  endtask

  task automatic add_row(input logic req, sel, awr, gr, mav, mwv, mbr,
                         input logic [1:0] sar, swr, sbv, input logic [7:0] beat);
    vec_t r;
    r = '{req, sel, awr, gr, mav, mwv, mbr, sar, swr, sbv, beat};
    tbl.push_back(r);
  endtask

  // Full write from master o; starts and ends in IDLE. rst_beat >= 0 aborts
  // the write with a reset pulse when that beat is offered.
  task automatic run_txn(input string name, input int o, input int n, input int aw_delay,
                         input int b_hold, input bit wtog, input bit sel_flip,
                         input int rst_beat);
    int k, guard, wcnt;
    cur_test = name;
    exp_q.delete();
    got_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back($urandom);
    S_AXI_awvalid[1-o] = 1;
    S_AXI_wvalid[1-o]  = 1;
    S_AXI_wlast[1-o]   = 1;
    S_AXI_bready[1-o]  = 1;
    S_AXI_wdata[(1-o)*DW +: DW] = 32'hDEAD_BEEF;
    Channel_Request = 1;
    Selected_Slave  = o[0];
    S_AXI_wvalid[o] = 1;
    S_AXI_wdata[o*DW +: DW] = exp_q[0];
    S_AXI_wlast[o] = (n == 1);
    cycle();
    Channel_Request = 0;
    cycle();
    if (sel_flip) Selected_Slave = ~o[0];
    Channel_Request = 1;
    S_AXI_awaddr[o*AW +: AW] = $urandom;
    M00_AXI_awready = 1;
    aw_hs = 0;
    guard = 0;
    while (!aw_hs && guard < aw_delay + 10) begin
      S_AXI_awvalid[o] = (guard >= aw_delay);
      cycle();
      guard++;
    end
    chk({name, " aw_handshake"}, aw_hs, 1);
    S_AXI_awvalid[o] = 0;
    Channel_Request  = 0;
    k = 0; wcnt = 0; guard = 0;
    while (k < n && guard < 3*n + 10) begin
      S_AXI_wdata[o*DW +: DW] = exp_q[k];
      S_AXI_wlast[o] = (k == n - 1);
      M00_AXI_wready = wtog ? (wcnt % 2 == 0) : 1'b1;
      if (k == rst_beat) ARESETN = 0;
      cycle();
      guard++;
      wcnt++;
      if (!ARESETN) begin
        ARESETN = 1;
        idle_inputs();
        chk({name, " beat_after_reset"}, Beat_Count, 0);
        chk({name, " granted_after_reset"}, Channel_Granted, 1);
        cycle();
        return;
      end
      if (w_hs) begin
        got_q.push_back(w_seen);
        k++;
      end
    end
    chk({name, " beats"}, k, n);
    for (int i = 0; i < got_q.size() && i < n; i++)
      chk($sformatf("%s wdata[%0d]", name, i), got_q[i], exp_q[i]);
    chk({name, " beat_count"}, Beat_Count, (n > 255) ? 255 : n);
    S_AXI_wvalid[o] = 0;
    S_AXI_wlast[o]  = 0;
    M00_AXI_bvalid  = 1;
    M00_AXI_bresp   = 2'($urandom_range(0, 3));
    b_hs = 0;
    guard = 0;
    while (!b_hs && guard < b_hold + 10) begin
      S_AXI_bready[o] = (guard >= b_hold);
      cycle();
      guard++;
    end
    chk({name, " b_cycles"}, guard, b_hold + 1);
    idle_inputs();
    chk({name, " granted_after_b"}, Channel_Granted, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m_busy = 0; m_cap = 0; m_aw = 0; m_w = 0; m_owner = 0; m_beats = 0;
    ARESETN = 0;
    idle_inputs();
    S_AXI_awvalid = 2'b11;
    M00_AXI_bvalid = 1;
    M00_AXI_awready = 1;
    @(posedge ACLK);
    #1;
    cycle();
    ARESETN = 1;
    idle_inputs();

    // Hand-derived 5-cycle single-beat writes: M0, then M1 with one AW stall.
    add_row(1, 0, 1,  1, 0, 0, 0,  2'b00, 2'b00, 2'b00, 8'd0);
    add_row(0, 0, 1,  0, 0, 0, 0,  2'b00, 2'b00, 2'b00, 8'd0);
    add_row(0, 0, 1,  0, 1, 0, 0,  2'b01, 2'b00, 2'b00, 8'd0);
    add_row(0, 0, 1,  0, 0, 1, 0,  2'b00, 2'b01, 2'b00, 8'd0);
    add_row(0, 0, 1,  0, 0, 0, 1,  2'b00, 2'b00, 2'b01, 8'd1);
    add_row(1, 1, 1,  1, 0, 0, 0,  2'b00, 2'b00, 2'b00, 8'd1);
    add_row(0, 1, 1,  0, 0, 0, 0,  2'b00, 2'b00, 2'b00, 8'd1);
    add_row(1, 1, 0,  0, 1, 0, 0,  2'b00, 2'b00, 2'b00, 8'd0);
    add_row(0, 1, 1,  0, 1, 0, 0,  2'b10, 2'b00, 2'b00, 8'd0);
    add_row(0, 0, 1,  0, 0, 1, 0,  2'b00, 2'b10, 2'b00, 8'd0);
    add_row(0, 0, 1,  0, 0, 0, 1,  2'b00, 2'b00, 2'b10, 8'd1);
    add_row(0, 0, 1,  1, 0, 0, 0,  2'b00, 2'b00, 2'b00, 8'd1);
    cur_test = "table";
    S_AXI_awaddr = {32'h2222_0000, 32'h1111_0000};
    S_AXI_wdata  = {32'hBBBB_0001, 32'hAAAA_0001};
    S_AXI_awvalid = 2'b11; S_AXI_wvalid = 2'b11; S_AXI_wlast = 2'b11; S_AXI_bready = 2'b11;
    M00_AXI_wready = 1; M00_AXI_bvalid = 1; M00_AXI_bresp = 2'b01;
    tbl_on = 1;
    for (int i = 0; i < tbl.size(); i++) begin
      tbl_idx = i;
      Channel_Request = tbl[i].req;
      Selected_Slave  = tbl[i].sel;
      M00_AXI_awready = tbl[i].awr;
      cycle();
    end
    tbl_on = 0;
    idle_inputs();

    run_txn("burst_m1",       1,   4, 0, 0, 1, 0, -1);
    run_txn("early_w_m0",     0,   2, 3, 0, 0, 0, -1);
    run_txn("sel_toggle",     0,   3, 0, 0, 0, 1, -1);
    run_txn("reset_mid_data", 0,   4, 0, 0, 0, 0,  2);
    run_txn("after_reset",    1,   2, 1, 0, 1, 0, -1);
    run_txn("b_backpressure", 1,   1, 0, 3, 0, 0, -1);
    run_txn("saturate",       0, 260, 0, 0, 0, 0, -1);

    cur_test = "random";
    for (int i = 0; i < 1500; i++) begin
      ARESETN         = ($urandom_range(0, 299) != 0);
      Channel_Request = ($urandom_range(0, 1) == 1);
      Selected_Slave  = ($urandom_range(0, 1) == 1);
      S_AXI_awaddr    = {$urandom, $urandom};
      S_AXI_wdata     = {$urandom, $urandom};
      S_AXI_awvalid   = 2'($urandom_range(0, 3));
      S_AXI_wvalid    = 2'($urandom_range(0, 3));
      S_AXI_wlast     = {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)};
      S_AXI_bready    = 2'($urandom_range(0, 3));
      M00_AXI_awready = ($urandom_range(0, 3) != 0);
      M00_AXI_wready  = ($urandom_range(0, 3) != 0);
      M00_AXI_bvalid  = ($urandom_range(0, 2) != 0);
      M00_AXI_bresp   = 2'($urandom_range(0, 3));
      cycle();
    end
    ARESETN = 1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
